// File: rtl/xpmwrap_pkg.sv
// Shared definitions for the xpmwrap FIFO read-side adapters.
package xpmwrap_pkg;

    // Output buffer depth of the read-stream adapter. Three entries are
    // enough to cover one in-flight FIFO word plus the registered head and
    // still run at one beat per cycle without looking at m_ready.
    localparam int RD_STREAM_BUF_DEPTH = 3;

    // Occupancy of the output buffer (0..3).
    typedef logic [1:0] rd_stream_lvl_t;

    // Index into the output buffer (0..2).
    typedef logic [1:0] rd_stream_ptr_t;

    // Advance a buffer index, wrapping after the last entry.
    function automatic rd_stream_ptr_t rd_stream_ptr_inc(input rd_stream_ptr_t p);
        return (p == rd_stream_ptr_t'(RD_STREAM_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/xpmwrap_fifo_rd_stream_if.sv
// Valid/ready stream carrying FIFO read data plus a frame-end marker.
interface xpmwrap_fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    // Producer side (the adapter).
    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    // Consumer side.
    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/xpmwrap_stream_buf.sv
// Three-entry register FIFO: push/pop in the same cycle, registered head
// and level, synchronous clear that wins over push and pop.
module xpmwrap_stream_buf
    import xpmwrap_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output rd_stream_lvl_t        level
);

    logic [DATA_WIDTH-1:0] r_mem [RD_STREAM_BUF_DEPTH];
    rd_stream_ptr_t        r_wr_ptr;
    rd_stream_ptr_t        r_rd_ptr;
    rd_stream_lvl_t        r_level;

    logic w_push;
    logic w_pop;

    // Clear dominates; a pop on an empty buffer is ignored so the level
    // can never underflow.
    assign w_push = push & ~clr;
    assign w_pop  = pop & (r_level != 2'd0) & ~clr;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_level  <= 2'd0;
        end else if (clr) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_level  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= rd_stream_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= rd_stream_ptr_inc(r_rd_ptr);
            end
            r_level <= r_level + rd_stream_lvl_t'(w_push) - rd_stream_lvl_t'(w_pop);
        end
    end

    // Storage; entries are reset so the head reads zero out of reset.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_STREAM_BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign level     = r_level;

endmodule

// File: rtl/xpmwrap_fifo_rd_stream.sv
// Read-side adapter for a latency-1 synchronous FIFO: issues rd_en from
// registered credit only, captures dout one cycle later into a 3-entry
// buffer and presents it as a valid/ready stream with optional framing.
module xpmwrap_fifo_rd_stream
    import xpmwrap_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int BEATS_PER_FRAME = 0,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                      wr_clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [DATA_WIDTH-1:0]     fifo_dout,
    input  logic                      fifo_empty,
    input  logic                      fifo_rd_rst_busy,
    output logic                      fifo_rd_en,
    xpmwrap_fifo_rd_stream_if.master  m,
    output rd_stream_lvl_t            buf_level
);

    logic                  r_infl;
    rd_stream_lvl_t        w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic [2:0]            w_committed;
    logic                  w_credit;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_last;

    // Entries already owned by the buffer plus the word on fifo_dout; a new
    // read is only allowed if its word is guaranteed a slot, which is what
    // lets the capture ignore m_ready entirely.
    assign w_committed = {1'b0, w_occ} + {2'b00, r_infl};
    assign w_credit    = (w_committed < 3'(RD_STREAM_BUF_DEPTH));

    // rst_n gates the enable directly so no read leaks out during reset.
    assign fifo_rd_en = rst_n & ~flush & ~fifo_empty & ~fifo_rd_rst_busy & w_credit;

    // In-flight flag: fifo_dout holds a real word in the cycle after rd_en.
    // flush already forces rd_en low, so it also clears this flag.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_infl <= 1'b0;
        end else begin
            r_infl <= fifo_rd_en;
        end
    end

    assign w_valid = (w_occ != 2'd0);
    assign w_pop   = w_valid & m.m_ready;

    xpmwrap_stream_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .wr_clk    (wr_clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (r_infl),
        .push_data (fifo_dout),
        .pop       (w_pop),
        .head_data (w_head),
        .level     (w_occ)
    );

    generate
        if (BEATS_PER_FRAME > 0) begin : gen_frame
            logic [FRAME_CNT_WIDTH-1:0] r_beat_cnt;

            assign w_last = (r_beat_cnt == FRAME_CNT_WIDTH'(BEATS_PER_FRAME - 1)) & w_valid;

            // Beat-in-frame counter: advances per accepted beat, wraps on the
            // last beat, restarts on flush.
            always_ff @(posedge wr_clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_beat_cnt <= '0;
                end else if (flush) begin
                    r_beat_cnt <= '0;
                end else if (w_pop) begin
                    r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
                end
            end
        end else begin : gen_no_frame
            assign w_last = 1'b0;
        end
    endgenerate

    assign m.m_data  = w_head;
    assign m.m_valid = w_valid;
    assign m.m_last  = w_last;
    assign buf_level = w_occ;

endmodule

// File: doc/xpmwrap_fifo_rd_stream.md
# xpmwrap_fifo_rd_stream

Read-side adapter placed directly downstream of the synchronous FIFO wrapper in standard (non-FWFT, read latency 1) mode. It drives the FIFO `rd_en`, captures `dout` one cycle later, and presents the data as a valid/ready stream with full one-beat-per-cycle throughput. There is no combinational path from `m_ready` to `rd_en`. An optional beat counter marks frame boundaries with `m_last`.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of FIFO `dout` and `m_data`.
- `BEATS_PER_FRAME`, 0, beats per frame for `m_last`; 0 disables framing.
- `FRAME_CNT_WIDTH`, 16, width of the beat-in-frame counter; requires `BEATS_PER_FRAME < 2**FRAME_CNT_WIDTH`.

Ports (one clock, `wr_clk`; reset `rst_n` is asynchronous and active-low):
- `wr_clk` in 1: clock, shared with the FIFO.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous clear of the buffer, in-flight read and frame counter.
- `fifo_dout` in DATA_WIDTH: FIFO read data.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_rst_busy` in 1: FIFO read-domain reset busy.
- `fifo_rd_en` out 1: FIFO read enable.
- `m_data` out DATA_WIDTH: stream data.
- `m_valid` out 1: stream valid.
- `m_last` out 1: last beat of a frame.
- `m_ready` in 1: downstream ready.
- `buf_level` out 2: number of entries held in the output buffer (0..3).

## Operation
- Output buffer: 3 entries, FIFO-ordered. `occ` is the registered occupancy; `infl` is a registered flag meaning `fifo_dout` is valid this cycle.
- `fifo_rd_en = rst_n & !flush & !fifo_empty & !fifo_rd_rst_busy & (occ + infl < 3)`. It uses only registered state and FIFO flags.
- `infl` next value is `fifo_rd_en`.
- When `infl` is high, `fifo_dout` is written to the tail at the clock edge. This happens regardless of `m_ready`; the credit rule guarantees space.
- `pop = m_valid & m_ready`. Next `occ` is `occ + infl - pop`.
- `m_valid` is `occ != 0`. `m_data` is the head entry. Both are registered; there is no `fifo_dout` bypass.
- Simultaneous write and pop with `occ = 3` cannot occur, since the credit rule keeps `occ + infl <= 3`. Simultaneous write and pop at any other level: head advances and tail appends in the same cycle.
- Framing (`BEATS_PER_FRAME > 0`):
  - `beat_cnt` increments on each `pop`.
  - `m_last` is `(beat_cnt == BEATS_PER_FRAME-1) & m_valid`.
  - On a pop with `m_last` high, `beat_cnt` wraps to 0.
  - With `BEATS_PER_FRAME = 1`, `m_last` equals `m_valid`.
  - With `BEATS_PER_FRAME = 0`, `m_last` is constant 0 and the counter is removed.
- `flush` (one cycle):
  - Next cycle: `occ = 0`, `infl = 0`, `beat_cnt = 0`.
  - A word arriving on `fifo_dout` during the flush cycle is discarded.
  - `fifo_rd_en` is 0 during flush.
  - A pop in the flush cycle still completes downstream. Flush takes priority for state.
- `fifo_rd_rst_busy` high: no new reads. Buffered data keeps draining normally.

## Timing
- Reset values: `fifo_rd_en` 0 (gated combinationally by `rst_n`), `m_valid` 0, `m_last` 0, `m_data` 0, `buf_level` 0, `occ` 0, `infl` 0, `beat_cnt` 0.
- Latency: `fifo_empty` falls in cycle c → `fifo_rd_en` high in c → data on `fifo_dout` in c+1 → `m_valid` high in c+2.
- Throughput: with `m_ready` held high and the FIFO non-empty, one beat per cycle is sustained indefinitely. Steady state is `occ = 1`, `infl = 1`.
- Backpressure: `m_ready` low → at most 3 words buffered, then `fifo_rd_en` stays low.
- AXI-style hold rule: once `m_valid` is high, `m_data` and `m_last` are stable until popped.

## Structure
- Shared package `xpmwrap_pkg`:
  - constant `RD_STREAM_BUF_DEPTH = 3`;
  - typedef `rd_stream_lvl_t` (2-bit level).
- Sub-module `xpmwrap_stream_buf`:
  - 3-entry register FIFO with push/pop, level output and synchronous clear.
  - The top level holds the credit logic, `infl` and the frame counter.

## Test plan
- Reset mid-traffic: assert `rst_n` low with `occ = 2` → all outputs 0 immediately. After release, FIFO holding 0xA1 gives `m_data = 0xA1`, `m_valid` high, 2 cycles after `fifo_rd_en`.
- Streaming: FIFO model preloaded with 0..99, `m_ready` held 1 → 100 beats on consecutive cycles, in order, with no gap after the first.
- Backpressure: `m_ready` low for 10 cycles with a non-empty FIFO → `buf_level` reaches 3, exactly 3 `fifo_rd_en` pulses, no data lost. Release `m_ready` → order preserved.
- Random `m_ready` (50%) with random `fifo_empty` → scoreboard matches and no read is issued while empty or `rd_rst_busy`.
- Framing: `BEATS_PER_FRAME = 4`, 12 beats → `m_last` on beats 3, 7 and 11 only. `flush` after beat 5 → the next beat counts as beat 0.
- Flush with in-flight word: `flush` in the cycle `fifo_dout` carries 0x55 → 0x55 never appears on `m_data`, and `buf_level` is 0 the next cycle.
